// File: rtl/sprite_writer.sv
// sprite_writer: streams one raster-ordered sprite into its VRAM slot, writing only during vblank
module sprite_writer #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [2:0]            sprite_index,
  input  logic                  abort,
  input  logic                  vblank,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);
  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE, DONE} state_t;
  state_t state, state_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0] idx;
  logic accept, last;
  // state register; reset forces IDLE so every decoded output drops at once
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= state_d;
  // next state and decoded outputs; abort overrides every transition
  always_comb begin
    state_d = state;
    in_ready = (state == WRITE) && vblank;
    busy = state != IDLE;
    done = state == DONE;
    accept = in_ready && in_valid && !abort;
    last = &x && &y;
    case (state)
      IDLE:       state_d = start ? (vblank ? WRITE : WAIT_BLANK) : IDLE;
      WAIT_BLANK: state_d = vblank ? WRITE : WAIT_BLANK;
      WRITE:      state_d = !vblank ? WAIT_BLANK : (accept && last) ? DONE : WRITE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // pixel counters and the registered VRAM write; power-of-two sizes make the address a concatenation
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      x <= '0;
      y <= '0;
      idx <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ADDR_WIDTH'({idx, y, x});
        wr_data <= in_data;
      end
      if (abort) begin
        x <= '0;
        y <= '0;
      end else if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
        idx <= sprite_index;
      end else if (accept) begin
        x <= x + 1'b1;
        if (&x) y <= y + 1'b1;
      end
    end
endmodule
